// File: rtl/serdes_lb_pkg.sv
// Shared types and helpers for the SERDES loopback RX checker.
package serdes_lb_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lb_state_e;

    localparam logic [7:0] KCHAR_DEF = 8'hBC;
    localparam logic [7:0] FILL_DEF  = 8'h4A;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  k;
    } lb_word_t;

    // Expected word: comma in lane pos, filler everywhere else
    function automatic lb_word_t exp_word(input logic [2:0] pos,
                                          input logic [7:0] kchar = KCHAR_DEF,
                                          input logic [7:0] fill  = FILL_DEF);
        lb_word_t w;
        w = '{data: 64'h0, k: 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (3'(i) == pos) begin
                w.data[8*i +: 8] = kchar;
                w.k[i]           = 1'b1;
            end else begin
                w.data[8*i +: 8] = fill;
                w.k[i]           = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serdes_lb_word_cmp.sv
// Combinational lane comparator: per-lane mismatch against the captured
// comma position, plus comma-candidate detection for hunting.
module serdes_lb_word_cmp
    import serdes_lb_pkg::*;
#(
    parameter logic [7:0] KCHAR = KCHAR_DEF,
    parameter logic [7:0] FILL  = FILL_DEF
) (
    input  logic [63:0] data_s,
    input  logic [7:0]  k_s,
    input  logic [7:0]  nit_s,
    input  logic [2:0]  pos_s,
    output logic [7:0]  bad_s,
    output logic [3:0]  nbad_s,
    output logic        cand_s,
    output logic [2:0]  cand_pos_s
);

    lb_word_t   exp_s;
    logic [7:0] comma_s;
    logic [7:0] fill_s;
    logic [3:0] ncomma_s;

    // Lane compare, popcount and single-comma candidate search
    always_comb begin
        exp_s      = exp_word(pos_s, KCHAR, FILL);
        bad_s      = 8'h00;
        nbad_s     = 4'd0;
        comma_s    = 8'h00;
        fill_s     = 8'h00;
        ncomma_s   = 4'd0;
        cand_pos_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            bad_s[i]   = (data_s[8*i +: 8] != exp_s.data[8*i +: 8]) |
                         (k_s[i] != exp_s.k[i]) | nit_s[i];
            nbad_s     = nbad_s + {3'd0, bad_s[i]};
            comma_s[i] = k_s[i] & (data_s[8*i +: 8] == KCHAR);
            fill_s[i]  = ~k_s[i] & (data_s[8*i +: 8] == FILL);
            ncomma_s   = ncomma_s + {3'd0, comma_s[i]};
            if (comma_s[i]) begin
                cand_pos_s = 3'(i);
            end else begin
                cand_pos_s = cand_pos_s;
            end
        end
        cand_s = (ncomma_s == 4'd1) && ((comma_s | fill_s) == 8'hFF) && (nit_s == 8'h00);
    end

endmodule

// File: rtl/serdes_lb_rx_checker.sv
// SERDES loopback receive checker: hunts for the comma lane, locks after a
// run of clean words and counts byte errors while locked.
module serdes_lb_rx_checker
    import serdes_lb_pkg::*;
#(
    parameter logic [7:0] KCHAR      = KCHAR_DEF,
    parameter logic [7:0] FILL       = FILL_DEF,
    parameter int         LOCK_CNT   = 16,
    parameter int         UNLOCK_CNT = 4,
    parameter int         CNT_W      = 32
) (
    input  logic             rx_clk,
    input  logic             rst_i,
    input  logic [63:0]      rx_data_i,
    input  logic [7:0]       rx_char_is_k_i,
    input  logic [7:0]       rx_not_in_table_i,
    input  logic             cnt_clr_i,
    output logic             locked_o,
    output logic [2:0]       comma_pos_o,
    output logic             word_err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam logic [7:0]       LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_C = 8'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [63:0]      d_r;
    logic [7:0]       k_r;
    logic [7:0]       nit_r;
    lb_state_e        state_r, state_nxt_s;
    logic [2:0]       pos_r, pos_nxt_s;
    logic [7:0]       good_r, good_nxt_s;
    logic [7:0]       badrun_r, badrun_nxt_s;
    logic             word_err_r, word_err_nxt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;
    logic [CNT_W-1:0] word_cnt_r, word_cnt_nxt_s;
    logic [CNT_W:0]   err_sum_s;
    logic             chk_s;
    logic [7:0]       bad_s;
    logic [3:0]       nbad_s;
    logic             cand_s;
    logic [2:0]       cand_pos_s;

    serdes_lb_word_cmp #(.KCHAR(KCHAR), .FILL(FILL)) u_cmp (
        .data_s     (d_r),
        .k_s        (k_r),
        .nit_s      (nit_r),
        .pos_s      (pos_r),
        .bad_s      (bad_s),
        .nbad_s     (nbad_s),
        .cand_s     (cand_s),
        .cand_pos_s (cand_pos_s)
    );

    // Input capture stage
    always_ff @(posedge rx_clk) begin
        if (rst_i) begin
            d_r   <= 64'h0;
            k_r   <= 8'h00;
            nit_r <= 8'h00;
        end else begin
            d_r   <= rx_data_i;
            k_r   <= rx_char_is_k_i;
            nit_r <= rx_not_in_table_i;
        end
    end

    // FSM state, comma position and run counters
    always_ff @(posedge rx_clk) begin
        if (rst_i) begin
            state_r  <= HUNT;
            pos_r    <= 3'd0;
            good_r   <= 8'd0;
            badrun_r <= 8'd0;
        end else begin
            state_r  <= state_nxt_s;
            pos_r    <= pos_nxt_s;
            good_r   <= good_nxt_s;
            badrun_r <= badrun_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HUNT: begin
                if (cand_s) begin
                    state_nxt_s = (LOCK_C == 8'd1) ? LOCKED : CHECK;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            CHECK: begin
                if (nbad_s != 4'd0) begin
                    state_nxt_s = HUNT;
                end else if ((good_r + 8'd1) == LOCK_C) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = CHECK;
                end
            end
            LOCKED: begin
                if ((nbad_s != 4'd0) && ((badrun_r + 8'd1) == UNLOCK_C)) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = HUNT;
        endcase
    end

    // Per-state datapath controls; badrun is cleared on every entry to LOCKED
    always_comb begin
        pos_nxt_s    = pos_r;
        good_nxt_s   = good_r;
        badrun_nxt_s = badrun_r;
        chk_s        = 1'b0;
        case (state_r)
            HUNT: begin
                if (cand_s) begin
                    pos_nxt_s    = cand_pos_s;
                    good_nxt_s   = 8'd1;
                    badrun_nxt_s = 8'd0;
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            CHECK: begin
                if (nbad_s == 4'd0) begin
                    good_nxt_s   = good_r + 8'd1;
                    badrun_nxt_s = 8'd0;
                end else begin
                    good_nxt_s = good_r;
                end
            end
            LOCKED: begin
                chk_s = 1'b1;
                if (nbad_s != 4'd0) begin
                    badrun_nxt_s = badrun_r + 8'd1;
                end else begin
                    badrun_nxt_s = 8'd0;
                end
            end
            default: chk_s = 1'b0;
        endcase
    end

    assign err_sum_s = {1'b0, err_cnt_r} + {{(CNT_W-3){1'b0}}, nbad_s};

    // Saturating counter next values; clear overrides any increment
    always_comb begin
        word_err_nxt_s = chk_s && (nbad_s != 4'd0);
        if (cnt_clr_i) begin
            err_cnt_nxt_s  = {CNT_W{1'b0}};
            word_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (chk_s) begin
            if (nbad_s == 4'd0) begin
                err_cnt_nxt_s = err_cnt_r;
            end else if (err_sum_s[CNT_W]) begin
                err_cnt_nxt_s = CNT_MAX;
            end else begin
                err_cnt_nxt_s = err_sum_s[CNT_W-1:0];
            end
            word_cnt_nxt_s = (word_cnt_r == CNT_MAX) ? word_cnt_r : word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_nxt_s  = err_cnt_r;
            word_cnt_nxt_s = word_cnt_r;
        end
    end

    // Registered error pulse and counters
    always_ff @(posedge rx_clk) begin
        if (rst_i) begin
            word_err_r <= 1'b0;
            err_cnt_r  <= {CNT_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            word_err_r <= word_err_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
            word_cnt_r <= word_cnt_nxt_s;
        end
    end

    assign locked_o    = (state_r == LOCKED);
    assign comma_pos_o = pos_r;
    assign word_err_o  = word_err_r;
    assign err_cnt_o   = err_cnt_r;
    assign word_cnt_o  = word_cnt_r;

endmodule

// File: tb/tb_serdes_lb_rx_checker.sv
// Randomized and directed bench for serdes_lb_rx_checker against a
// lane-counting reference model; a second instance uses 8-bit counters.
module tb_serdes_lb_rx_checker;

    logic        rx_clk;
    logic        rst_i;
    logic [63:0] rx_data_i;
    logic [7:0]  rx_char_is_k_i;
    logic [7:0]  rx_not_in_table_i;
    logic        cnt_clr_i;

    logic        locked_a, locked_b;
    logic [2:0]  pos_a, pos_b;
    logic        werr_a, werr_b;
    logic [31:0] err_a, wc_a;
    logic [7:0]  err_b, wc_b;

    serdes_lb_rx_checker dut (
        .rx_clk(rx_clk), .rst_i(rst_i), .rx_data_i(rx_data_i),
        .rx_char_is_k_i(rx_char_is_k_i), .rx_not_in_table_i(rx_not_in_table_i),
        .cnt_clr_i(cnt_clr_i), .locked_o(locked_a), .comma_pos_o(pos_a),
        .word_err_o(werr_a), .err_cnt_o(err_a), .word_cnt_o(wc_a)
    );

    serdes_lb_rx_checker #(.CNT_W(8)) dut8 (
        .rx_clk(rx_clk), .rst_i(rst_i), .rx_data_i(rx_data_i),
        .rx_char_is_k_i(rx_char_is_k_i), .rx_not_in_table_i(rx_not_in_table_i),
        .cnt_clr_i(cnt_clr_i), .locked_o(locked_b), .comma_pos_o(pos_b),
        .word_err_o(werr_b), .err_cnt_o(err_b), .word_cnt_o(wc_b)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] p_d;
    logic [7:0]  p_k, p_nit;
    bit          m_locked, m_err;
    int          m_pos, m_run, m_badrun;
    longint      m_err32, m_wc32, m_err8, m_wc8;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] good_data(input int pos);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = (i == pos) ? 8'hBC : 8'h4A;
        return d;
    endfunction

    function automatic logic [7:0] good_k(input int pos);
        logic [7:0] k;
        k = 8'h00;
        k[pos] = 1'b1;
        return k;
    endfunction

    function automatic int lane_errs(input logic [63:0] d, input logic [7:0] k,
                                     input logic [7:0] nit, input int pos);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == pos) begin
                if (d[8*i +: 8] != 8'hBC || k[i] != 1'b1 || nit[i]) n++;
            end else begin
                if (d[8*i +: 8] != 8'h4A || k[i] != 1'b0 || nit[i]) n++;
            end
        end
        return n;
    endfunction

    // returns the single comma lane of a clean pattern word, else -1
    function automatic int find_comma(input logic [63:0] d, input logic [7:0] k, input logic [7:0] nit);
        int commas, fills, where;
        commas = 0; fills = 0; where = -1;
        for (int i = 0; i < 8; i++) begin
            if (k[i] && d[8*i +: 8] == 8'hBC) begin commas++; where = i; end
            if (!k[i] && d[8*i +: 8] == 8'h4A) fills++;
        end
        if (commas == 1 && fills == 7 && nit == 8'h00) return where;
        return -1;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic model_edge(input logic clr, input logic rst);
        int nb, c;
        m_err = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_pos = 0; m_run = 0; m_badrun = 0;
            m_err32 = 0; m_wc32 = 0; m_err8 = 0; m_wc8 = 0;
            return;
        end
        nb = lane_errs(p_d, p_k, p_nit, m_pos);
        if (m_locked) begin
            m_wc32 = sat_add(m_wc32, 1, 64'hFFFF_FFFF);
            m_wc8  = sat_add(m_wc8, 1, 255);
            if (nb > 0) begin
                m_err = 1'b1;
                m_err32 = sat_add(m_err32, nb, 64'hFFFF_FFFF);
                m_err8  = sat_add(m_err8, nb, 255);
                m_badrun++;
                if (m_badrun == 4) begin m_locked = 1'b0; m_run = 0; end
            end else begin
                m_badrun = 0;
            end
        end else if (m_run == 0) begin
            c = find_comma(p_d, p_k, p_nit);
            if (c >= 0) begin m_pos = c; m_run = 1; end
        end else if (nb == 0) begin
            m_run++;
            if (m_run == 16) begin m_locked = 1'b1; m_badrun = 0; end
        end else begin
            m_run = 0;
        end
        if (clr) begin m_err32 = 0; m_wc32 = 0; m_err8 = 0; m_wc8 = 0; end
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] k, input logic [7:0] nit,
                        input logic clr, input logic rst);
        rx_data_i = d; rx_char_is_k_i = k; rx_not_in_table_i = nit;
        cnt_clr_i = clr; rst_i = rst;
        @(posedge rx_clk);
        #1;
        model_edge(clr, rst);
        if (rst) begin p_d = 64'h0; p_k = 8'h00; p_nit = 8'h00; end
        else begin p_d = d; p_k = k; p_nit = nit; end
        chk("locked",    64'(locked_a), 64'(m_locked));
        chk("comma_pos", 64'(pos_a),    64'(m_pos));
        chk("word_err",  64'(werr_a),   64'(m_err));
        chk("err_cnt",   64'(err_a),    64'(m_err32));
        chk("word_cnt",  64'(wc_a),     64'(m_wc32));
        chk("locked8",   64'(locked_b), 64'(m_locked));
        chk("word_err8", 64'(werr_b),   64'(m_err));
        chk("err_cnt8",  64'(err_b),    64'(m_err8));
        chk("word_cnt8", 64'(wc_b),     64'(m_wc8));
    endtask

    task automatic good(input int pos, input logic clr);
        step(good_data(pos), good_k(pos), 8'h00, clr, 1'b0);
    endtask

    initial begin
        logic [63:0] d, amb;
        logic [7:0]  k, nit;
        int pos, ln;
        p_d = 64'h0; p_k = 8'h00; p_nit = 8'h00;
        model_edge(1'b0, 1'b1);

        for (int i = 0; i < 3; i++) step(64'h0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("reset_locked", 64'(locked_a), 64'd0);

        // lock on lane 1
        for (int i = 1; i <= 20; i++) begin
            step(64'h4A4A4A4A_4A4ABC4A, 8'h02, 8'h00, 1'b0, 1'b0);
            if (i == 16) chk("lock_early", 64'(locked_a), 64'd0);
            if (i == 17) chk("lock_rise", 64'(locked_a), 64'd1);
        end
        chk("lock_pos", 64'(pos_a), 64'd1);
        chk("lock_wc", 64'(wc_a), 64'd3);

        // single error on lane 5
        d = good_data(1);
        d[47:40] = 8'h00;
        step(d, 8'h02, 8'h00, 1'b0, 1'b0);
        good(1, 1'b0);
        chk("single_pulse", 64'(werr_a), 64'd1);
        chk("single_cnt", 64'(err_a), 64'd1);
        good(1, 1'b0);
        chk("single_end", 64'(werr_a), 64'd0);
        chk("single_lock", 64'(locked_a), 64'd1);

        // unlock after four all-zero words
        good(1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(64'h0, 8'h00, 8'h00, 1'b0, 1'b0);
            if (i == 5) begin
                chk("unlock_cnt", 64'(err_a), 64'd32);
                chk("unlock_state", 64'(locked_a), 64'd0);
            end
        end
        good(1, 1'b0);
        chk("unlock_fifth", 64'(err_a), 64'd32);

        // ambiguous commas in lanes 0 and 3
        amb = 64'h4A4A4A4A_BC4A4ABC;
        for (int i = 0; i < 40; i++) step(amb, 8'h09, 8'h00, 1'b0, 1'b0);
        chk("ambiguous", 64'(locked_a), 64'd0);

        // saturation on the 8-bit instance
        for (int i = 0; i < 20; i++) good(6, 1'b0);
        good(6, 1'b1);
        for (int i = 0; i < 31; i++) begin
            step(64'h0, 8'h00, 8'h00, 1'b0, 1'b0);
            good(6, 1'b0);
        end
        step(good_data(6) & ~64'hFFFF, good_k(6), 8'h00, 1'b0, 1'b0);
        good(6, 1'b0);
        chk("sat_250", 64'(err_b), 64'd250);
        step(64'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        good(6, 1'b0);
        chk("sat_255", 64'(err_b), 64'd255);
        chk("sat_wide", 64'(err_a), 64'd258);

        // clear colliding with an error word
        step(64'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        good(6, 1'b1);
        chk("clr_err", 64'(err_a), 64'd0);
        chk("clr_wc", 64'(wc_a), 64'd0);
        chk("clr_pulse", 64'(werr_a), 64'd1);

        // randomized traffic
        pos = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 300 == 0) pos = $urandom_range(0, 7);
            d = good_data(pos);
            k = good_k(pos);
            nit = 8'h00;
            if ($urandom_range(0, 15) == 0) begin
                ln = $urandom_range(0, 7);
                d[8*ln +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) k[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) nit[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 63) == 0) begin
                d = {$urandom, $urandom};
                k = 8'($urandom);
            end
            if ($urandom_range(0, 127) == 0) begin d = amb; k = 8'h09; end
            step(d, k, nit, ($urandom_range(0, 99) == 0), ($urandom_range(0, 999) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serdes_lb_rx_checker.md
# serdes_lb_rx_checker

Receive-side checker for the SERDES loopback test. It runs on the recovered RX clock and consumes the 64-bit RX data and per-byte status from the SERDES primitive. The transmitter sends a fixed comma pattern: one comma byte in a fixed lane, with filler bytes in every other lane. This block finds the comma lane, locks onto it, and counts byte errors once locked. Its outputs drive the board LEDs and debug headers beside the existing status signals.

## Interface
Parameters:
- `KCHAR`, 8'hBC, comma byte (K28.5); its lane must have K=1
- `FILL`, 8'h4A, filler byte; its lanes must have K=0
- `LOCK_CNT`, 16, consecutive matching words needed to lock (1..255)
- `UNLOCK_CNT`, 4, consecutive mismatching words while locked that force a drop to hunt (1..255)
- `CNT_W`, 32, width of the error and word counters

Ports:
- `rx_clk` in 1: recovered RX clock; this is the block's only clock
- `rst_i` in 1: reset, synchronous and active-high
- `rx_data_i` in 64: RX data; byte lane i is bits [8i+7:8i]
- `rx_char_is_k_i` in 8: per-lane K flag
- `rx_not_in_table_i` in 8: per-lane 8b/10b code violation
- `cnt_clr_i` in 1: synchronous clear of the counters
- `locked_o` out 1: checker is in the LOCKED state
- `comma_pos_o` out 3: captured comma lane
- `word_err_o` out 1: one-cycle pulse for each mismatching word while locked
- `err_cnt_o` out CNT_W: saturating count of mismatching bytes while locked
- `word_cnt_o` out CNT_W: saturating count of words checked while locked

## Operation
- Stage 1 registers `rx_data_i`, `rx_char_is_k_i` and `rx_not_in_table_i` into `d_q`, `k_q` and `nit_q`.
- Stage 2 compares each lane i against the expected byte for the captured position P:
  - lane P: data = KCHAR and K = 1
  - every other lane: data = FILL and K = 0
  - every lane: not_in_table = 0
  - `bad[7:0]` is the per-lane mismatch vector; `nbad` = popcount(`bad`), 0..8.
- A candidate word has exactly one lane with K=1 and data=KCHAR, all other lanes match the filler rule, and `nit_q` is 0. Its candidate position is the index of the comma lane.
- State machine (`good` and `badrun` are 8-bit counters):
  - HUNT: on a candidate word, set P to the candidate position and `good` = 1. Go to LOCKED if LOCK_CNT = 1, otherwise go to CHECK. Any other word leaves the state in HUNT.
  - CHECK: if `nbad` = 0, increment `good`; when `good` reaches LOCK_CNT, go to LOCKED and clear `badrun`. If `nbad` ≠ 0, go to HUNT. No counting happens in CHECK.
  - LOCKED:
    - Every word increments `word_cnt`.
    - If `nbad` ≠ 0: `err_cnt` += `nbad`, `word_err_o` pulses, `badrun` increments. When `badrun` reaches UNLOCK_CNT, go to HUNT.
    - If `nbad` = 0: clear `badrun`.
- Counter arithmetic:
  - `err_cnt` is computed at CNT_W+1 bits; if the result exceeds the all-ones value, it clamps to all-ones.
  - `word_cnt` stops incrementing at all-ones.
- `cnt_clr_i`:
  - Zeroes `err_cnt` and `word_cnt` on the same edge.
  - It wins over a simultaneous increment.
  - It does not affect the state, P, `good` or `badrun`.
- P changes only in HUNT. In LOCKED, a comma in a different lane counts as errors and is never re-captured.

## Timing
- Latency: a word present at the input before edge N is registered at edge N. Its effect on state, counters and outputs is visible after edge N+1.
- `word_err_o` is registered and high for exactly one cycle per mismatching locked word.
- Back-to-back errors give a continuous high on `word_err_o`.
- The checker accepts one word every cycle; there is no valid signal and no backpressure.
- Reset values, held while `rst_i` is high:
  - state HUNT; P = 0; `good` = 0; `badrun` = 0
  - all pipeline registers 0
  - `locked_o` = 0, `comma_pos_o` = 0, `word_err_o` = 0, `err_cnt_o` = 0, `word_cnt_o` = 0
- Reset asserted mid-lock takes effect on that edge. The first word after reset is released is registered on the first edge with `rst_i` low.
- `locked_o` and `comma_pos_o` are driven directly from the state and P registers.

## Structure
- Package `serdes_lb_pkg` holds:
  - the state enum (HUNT, CHECK, LOCKED)
  - the default KCHAR and FILL constants
  - the function `exp_word(pos)` returning the expected 64-bit data and 8-bit K vector for a position
- Sub-module `serdes_lb_word_cmp` is purely combinational. It takes data, K, not_in_table and P, and returns `bad[7:0]`, `nbad[3:0]`, a candidate flag and the candidate position.

## Test plan
- Lock: after reset, stream 0x4A4A4A4A_4A4ABC4A with K = 0x02. `locked_o` rises 2 cycles after the 16th word, with `comma_pos_o` = 1, `err_cnt_o` = 0 and `word_cnt_o` counting from the next word.
- Single error: while locked, send one word with lane 5 = 0x00. Then `word_err_o` is a single pulse, `err_cnt_o` = 1, and `locked_o` stays 1.
- Unlock: while locked, send 4 consecutive all-0x00 words with K = 0. Then `err_cnt_o` = 32 (4 words × 8 lanes) and `locked_o` = 0 after the 4th word. A 5th bad word leaves `err_cnt_o` unchanged.
- Ambiguous comma: in HUNT, stream words with BC and K=1 in lanes 0 and 3. `locked_o` stays 0 indefinitely.
- Saturation: with CNT_W = 8 and `err_cnt_o` = 250, one all-bad word (8 lane errors) makes `err_cnt_o` = 255.
- Clear collision: assert `cnt_clr_i` on the same cycle an error word is evaluated. Both counters read 0 the next cycle, while `word_err_o` still pulses.
